// File: rtl/truth_table_scanner.sv
// -----------------------------------------------------------------------------
// truth_table_scanner
//
// Self-check stage wrapped around a 4-input SOP gate block. It walks the
// block's inputs {a,b,c,d} through minterms 0..15 and holds each one for
// SETTLE_CYC cycles. It then samples the block output (f_in) into word[k] and
// compares the finished 16-bit truth table against EXPECTED.
//
// Optional feature macro: SCAN_FIRST_FAIL_EN
//   defined   -> fail_idx reports the lowest minterm whose sample differed
//                from EXPECTED.
//   undefined -> fail_idx is tied to 4'h0 and no mismatch tracking exists.
//
// Parameters:
//   EXPECTED    expected truth table, bit k = function value at minterm k
//   SETTLE_CYC  cycles each minterm is held before sampling (1..15)
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   scan request, only honoured in IDLE
//   f_in      in   SOP block output fed back
//   a,b,c,d   out  minterm drive, {a,b,c,d} = current index (a is MSB)
//   busy      out  high from the accepting edge until the return to IDLE
//   done      out  level, high once a scan completes
//   pass      out  word == EXPECTED, valid while done = 1
//   word      out  captured truth table
//   fail_idx  out  lowest mismatching minterm (see macro above)
// -----------------------------------------------------------------------------
module truth_table_scanner #(
    parameter logic [15:0] EXPECTED   = 16'hA655,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        f_in,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] word,
    output logic [3:0]  fail_idx
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC);

    logic [1:0]  state_r;
    logic [3:0]  idx_r;
    logic [3:0]  settle_cnt_r;
    logic [3:0]  abcd_r;
    logic        busy_r;
    logic        done_r;
    logic        pass_r;
    logic [15:0] word_r;
    logic [3:0]  settle_inc_s;

    // Settle counter value after this cycle's increment.
    always_comb begin
        settle_inc_s = settle_cnt_r + 4'd1;
    end

    // Scan sequencer: minterm drive, sampling, and completion flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            idx_r        <= 4'd0;
            settle_cnt_r <= 4'd0;
            abcd_r       <= 4'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            word_r       <= 16'h0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        idx_r        <= 4'd0;
                        settle_cnt_r <= 4'd0;
                        abcd_r       <= 4'd0;
                        word_r       <= 16'h0000;
                        done_r       <= 1'b0;
                        pass_r       <= 1'b0;
                        busy_r       <= 1'b1;
                        state_r      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    settle_cnt_r <= settle_inc_s;
                    if (settle_inc_s == SETTLE_LAST) begin
                        state_r <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    word_r[idx_r] <= f_in;
                    settle_cnt_r  <= 4'd0;
                    if (idx_r == 4'd15) begin
                        // Drive stays at 4'hF through FINISH and IDLE.
                        state_r <= ST_FINISH;
                    end else begin
                        // The next minterm goes out on the same edge that
                        // samples the current one.
                        idx_r   <= idx_r + 4'd1;
                        abcd_r  <= idx_r + 4'd1;
                        state_r <= ST_SETTLE;
                    end
                end
                ST_FINISH: begin
                    pass_r  <= (word_r == EXPECTED);
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SCAN_FIRST_FAIL_EN
    logic       fail_seen_r;
    logic [3:0] fail_idx_r;

    // Latch the first mismatching minterm of the current scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_seen_r <= 1'b0;
            fail_idx_r  <= 4'd0;
        end else if ((state_r == ST_IDLE) && start) begin
            fail_seen_r <= 1'b0;
            fail_idx_r  <= 4'd0;
        end else if ((state_r == ST_SAMPLE) && !fail_seen_r &&
                     (f_in != EXPECTED[idx_r])) begin
            fail_seen_r <= 1'b1;
            fail_idx_r  <= idx_r;
        end
    end

    assign fail_idx = fail_idx_r;
`else
    assign fail_idx = 4'h0;
`endif

    assign a    = abcd_r[3];
    assign b    = abcd_r[2];
    assign c    = abcd_r[1];
    assign d    = abcd_r[0];
    assign busy = busy_r;
    assign done = done_r;
    assign pass = pass_r;
    assign word = word_r;

endmodule

// File: tb/tb_truth_table_scanner.sv
// -----------------------------------------------------------------------------
// tb_truth_table_scanner
//
// Two scanner instances share one clock: dut0 with SETTLE_CYC=2 and dut1 with
// SETTLE_CYC=1. The SOP block is modelled as a 16-entry lookup table (mask_r)
// indexed by the scanner's own {a,b,c,d}. Expected timing comes from the
// edge arithmetic of the scan (minterm k held from edge k*(S+1), done at
// edge 16*(S+1)+1). Expected results come straight from the table.
// -----------------------------------------------------------------------------
module tb_truth_table_scanner;

    localparam logic [15:0] GOLD = 16'hA655;

    logic        clk;
    logic        rst_n;
    logic        start0, start1;
    logic [15:0] mask_r;
    int          sel;
    int          errors;
    int          checks;

    logic        a0, b0, c0, d0, busy0, done0, pass0, f0;
    logic [15:0] word0;
    logic [3:0]  fidx0;
    logic        a1, b1, c1, d1, busy1, done1, pass1, f1;
    logic [15:0] word1;
    logic [3:0]  fidx1;

    logic [3:0]  s_abcd;
    logic        s_busy, s_done, s_pass;
    logic [15:0] s_word;
    logic [3:0]  s_fidx;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SOP block: function value looked up by minterm index.
    assign f0 = mask_r[{a0, b0, c0, d0}];
    assign f1 = mask_r[{a1, b1, c1, d1}];

    truth_table_scanner #(.EXPECTED(GOLD), .SETTLE_CYC(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .f_in(f0),
        .a(a0), .b(b0), .c(c0), .d(d0),
        .busy(busy0), .done(done0), .pass(pass0),
        .word(word0), .fail_idx(fidx0)
    );

    truth_table_scanner #(.EXPECTED(GOLD), .SETTLE_CYC(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .f_in(f1),
        .a(a1), .b(b1), .c(c1), .d(d1),
        .busy(busy1), .done(done1), .pass(pass1),
        .word(word1), .fail_idx(fidx1)
    );

    always_comb begin
        if (sel == 1) begin
            s_abcd = {a1, b1, c1, d1};
            s_busy = busy1; s_done = done1; s_pass = pass1;
            s_word = word1; s_fidx = fidx1;
        end else begin
            s_abcd = {a0, b0, c0, d0};
            s_busy = busy0; s_done = done0; s_pass = pass0;
            s_word = word0; s_fidx = fidx0;
        end
    end

    // Full scan on instance s with function table m; start is re-pulsed at
    // edges rp_a / rp_b (use -1 for none) to confirm it is ignored.
    task automatic scan(input int s, input logic [15:0] m, input int rp_a,
                        input int rp_b, input string tag);
        int          set;
        int          dedge;
        logic [3:0]  exp_abcd;
        logic        exp_busy, exp_done, exp_pass, ref_pass;
        logic [3:0]  exp_fidx;
        set      = (s == 1) ? 1 : 2;
        dedge    = 16 * (set + 1) + 1;
        sel      = s;
        mask_r   = m;
        ref_pass = (m == GOLD);
        exp_fidx = 4'd0;
`ifdef SCAN_FIRST_FAIL_EN
        for (int k = 15; k >= 0; k--) begin
            if (m[k] != GOLD[k]) exp_fidx = 4'(k);
        end
`endif
        @(negedge clk);
        if (s == 1) start1 = 1'b1; else start0 = 1'b1;
        for (int n = 0; n <= dedge; n++) begin
            @(posedge clk);
            #1;
            if (s == 1) start1 = ((n + 1) == rp_a) || ((n + 1) == rp_b);
            else        start0 = ((n + 1) == rp_a) || ((n + 1) == rp_b);
            exp_abcd = (n < 16 * (set + 1)) ? 4'(n / (set + 1)) : 4'hF;
            exp_busy = (n < dedge);
            exp_done = (n == dedge);
            exp_pass = (n == dedge) ? ref_pass : 1'b0;
            checks++;
            if (s_abcd !== exp_abcd) begin
                errors++;
                $display("FAIL %s abcd edge %0d: got %h want %h", tag, n, s_abcd, exp_abcd);
            end
            checks++;
            if (s_busy !== exp_busy) begin
                errors++;
                $display("FAIL %s busy edge %0d: got %b want %b", tag, n, s_busy, exp_busy);
            end
            checks++;
            if (s_done !== exp_done) begin
                errors++;
                $display("FAIL %s done edge %0d: got %b want %b", tag, n, s_done, exp_done);
            end
            checks++;
            if (s_pass !== exp_pass) begin
                errors++;
                $display("FAIL %s pass edge %0d: got %b want %b", tag, n, s_pass, exp_pass);
            end
            if (n == 0) begin
                checks++;
                if (s_word !== 16'h0000) begin
                    errors++;
                    $display("FAIL %s word_clear: got %h want 0000", tag, s_word);
                end
            end
        end
        checks++;
        if (s_word !== m) begin
            errors++;
            $display("FAIL %s word: got %h want %h", tag, s_word, m);
        end
        checks++;
        if (s_fidx !== exp_fidx) begin
            errors++;
            $display("FAIL %s fail_idx: got %h want %h", tag, s_fidx, exp_fidx);
        end
    endtask

    function automatic logic [15:0] table_of(input int mts[8]);
        logic [15:0] t;
        t = 16'h0000;
        foreach (mts[i]) t[mts[i]] = 1'b1;
        return t;
    endfunction

    task automatic check_all_zero(input string tag);
        checks++;
        if ({a0, b0, c0, d0, busy0, done0, pass0, word0, fidx0} !== 27'd0) begin
            errors++;
            $display("FAIL %s dut0 outputs: got %h want 0", tag,
                     {a0, b0, c0, d0, busy0, done0, pass0, word0, fidx0});
        end
        checks++;
        if ({a1, b1, c1, d1, busy1, done1, pass1, word1, fidx1} !== 27'd0) begin
            errors++;
            $display("FAIL %s dut1 outputs: got %h want 0", tag,
                     {a1, b1, c1, d1, busy1, done1, pass1, word1, fidx1});
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        mask_r = 16'h0000;
        sel    = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_golden();
        int gold_mts[8] = '{0, 2, 4, 6, 9, 10, 13, 15};
        scan(0, table_of(gold_mts), -1, -1, "golden");
    endtask

    task automatic test_faulty();
        int bad_mts[8] = '{0, 2, 3, 4, 6, 10, 13, 15};
        scan(0, table_of(bad_mts), -1, -1, "faulty");
    endtask

    task automatic test_start_ignored();
        scan(0, GOLD, 5, 20, "restart_ignored");
    endtask

    task automatic test_reset_mid_scan();
        sel    = 0;
        mask_r = GOLD;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (21) @(posedge clk);
        #1;
        checks++;
        if ({a0, b0, c0, d0} !== 4'd7) begin
            errors++;
            $display("FAIL mid_reset idx: got %h want 7", {a0, b0, c0, d0});
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        scan(0, GOLD, -1, -1, "after_reset");
    endtask

    task automatic test_settle1();
        scan(1, GOLD, -1, -1, "settle1");
    endtask

    task automatic test_back_to_back();
        scan(0, GOLD, -1, -1, "b2b_first");
        scan(0, GOLD, -1, -1, "b2b_second");
    endtask

    task automatic test_random();
        logic [15:0] m;
        int          s;
        for (int i = 0; i < 6; i++) begin
            s = int'($urandom_range(0, 1));
            m = 16'($urandom);
            if (i == 0) m = GOLD;
            if (i == 1) m = GOLD ^ (16'h0001 << $urandom_range(0, 15));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            scan(s, m, int'($urandom_range(1, 30)), -1, "random");
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_golden();
        test_faulty();
        test_start_ignored();
        test_reset_mid_scan();
        test_settle1();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
